// File: rtl/data_island_scheduler.sv
// Data-island scheduler: sequences a blanking interval into preamble, guard bands and 32-pixel
// packets, arbitrating requesters with fixed priority for index 0 and round-robin for the rest.
module data_island_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_PACKETS = 18,
    parameter int CTRL_TAIL   = 12,
    parameter int CTRL_LEAD   = 4
) (
    input  logic                       clk_pixel,
    input  logic                       reset_n,
    input  logic                       blank_start,
    input  logic [11:0]                blank_length,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] packet_sel,
    output logic                       packet_enable,
    output logic [4:0]                 packet_pixel_counter,
    output logic [2:0]                 mode,
    output logic                       overrun
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PKT_W = $clog2(MAX_PACKETS + 1);

    // Budgets: opening needs preamble+guard+packet+guard (44), continuing needs packet+guard (34).
    localparam logic [11:0]      OPEN_MIN  = 12'(44 + CTRL_TAIL);
    localparam logic [11:0]      NEXT_MIN  = 12'(34 + CTRL_TAIL);
    localparam logic [PKT_W-1:0] PKT_MAX   = PKT_W'(MAX_PACKETS);
    localparam logic [7:0]       LEAD_LOAD = 8'(CTRL_LEAD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    localparam logic [2:0] MODE_CTRL   = 3'd0;
    localparam logic [2:0] MODE_PRE    = 3'd1;
    localparam logic [2:0] MODE_LGUARD = 3'd2;
    localparam logic [2:0] MODE_DATA   = 3'd3;
    localparam logic [2:0] MODE_TGUARD = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        CTRL_WAIT,
        PREAMBLE,
        LEAD_GUARD,
        PACKET,
        TRAIL_GUARD,
        DONE
    } state_t;

    state_t           state;
    logic [11:0]      rem;
    logic [7:0]       cnt;
    logic [PKT_W-1:0] packets_in_island;
    logic [IDX_W-1:0] rr_ptr;

    logic             win_valid;
    logic [IDX_W-1:0] win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W-1:0] rr_next;
    logic             any_req;
    logic             in_island;
    logic             more_packets;
    logic             start_pkt;

    // Index 0 wins outright; otherwise scan 1..NUM_REQ-1 starting at the round-robin pointer.
    always_comb begin
        int cand;
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        if (req[0]) begin
            win_valid = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ - 1; k++) begin
                cand = int'(rr_ptr) + k;
                if (cand >= NUM_REQ) cand = cand - (NUM_REQ - 1);
                if (!win_valid && req[IDX_W'(cand)]) begin
                    win_valid = 1'b1;
                    win_idx   = IDX_W'(cand);
                end
            end
        end
    end

    assign win_onehot   = win_valid ? (NUM_REQ'(1) << win_idx) : '0;
    assign rr_next      = (win_idx == LAST_IDX) ? IDX_W'(1) : IDX_W'(win_idx + 1'b1);
    assign any_req      = |req;
    assign in_island    = state inside {PREAMBLE, LEAD_GUARD, PACKET, TRAIL_GUARD};
    assign more_packets = any_req && (packets_in_island < PKT_MAX) && (rem >= NEXT_MIN);
    assign start_pkt    = ((state == LEAD_GUARD) && (cnt == 8'd0)) ||
                          ((state == PACKET) && (packet_pixel_counter == 5'd31) && more_packets);

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            state                <= IDLE;
            rem                  <= '0;
            cnt                  <= '0;
            packets_in_island    <= '0;
            rr_ptr               <= IDX_W'(1);
            grant                <= '0;
            packet_sel           <= '0;
            packet_enable        <= 1'b0;
            packet_pixel_counter <= '0;
            mode                 <= MODE_CTRL;
            overrun              <= 1'b0;
        end else begin
            grant         <= '0;
            packet_enable <= 1'b0;

            if (blank_start && in_island) overrun <= 1'b1;

            // rem tracks pixels left after the current cycle; the blank_start cycle itself is cycle 0.
            if (blank_start && !in_island)
                rem <= (blank_length >= 12'd2) ? blank_length - 12'd2 : 12'd0;
            else if (rem != 12'd0)
                rem <= rem - 12'd1;

            case (state)
                IDLE, DONE: begin
                    if (blank_start) begin
                        state <= CTRL_WAIT;
                        cnt   <= LEAD_LOAD;
                    end
                end
                CTRL_WAIT: begin
                    if (blank_start) begin
                        cnt <= LEAD_LOAD;
                    end else if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else if (any_req && (rem >= OPEN_MIN)) begin
                        state             <= PREAMBLE;
                        cnt               <= 8'd7;
                        mode              <= MODE_PRE;
                        packets_in_island <= '0;
                    end else begin
                        state <= DONE;
                    end
                end
                PREAMBLE: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state <= LEAD_GUARD;
                        cnt   <= 8'd1;
                        mode  <= MODE_LGUARD;
                    end
                end
                LEAD_GUARD: begin
                    if (cnt != 8'd0) cnt <= cnt - 8'd1;
                end
                PACKET: begin
                    if (packet_pixel_counter != 5'd31) begin
                        packet_pixel_counter <= packet_pixel_counter + 5'd1;
                    end else if (!more_packets) begin
                        state                <= TRAIL_GUARD;
                        cnt                  <= 8'd1;
                        mode                 <= MODE_TGUARD;
                        packet_pixel_counter <= '0;
                    end
                end
                TRAIL_GUARD: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state <= DONE;
                        mode  <= MODE_CTRL;
                    end
                end
                default: begin
                    state <= IDLE;
                    mode  <= MODE_CTRL;
                end
            endcase

            // A withdrawn request still yields a packet slot so an opened island is never empty.
            if (start_pkt) begin
                state                <= PACKET;
                mode                 <= MODE_DATA;
                packet_pixel_counter <= '0;
                packet_enable        <= 1'b1;
                grant                <= win_onehot;
                packets_in_island    <= packets_in_island + 1'b1;
                if (win_valid) packet_sel <= win_idx;
                if (win_valid && (win_idx != '0)) rr_ptr <= rr_next;
            end
        end
    end

endmodule

// File: tb/tb_data_island_scheduler.sv
// Bench for data_island_scheduler: timeline-based reference model checked every cycle,
// plus hand-computed expectations at key cycles of each directed scenario.
module tb_data_island_scheduler;
    localparam int NUM_REQ     = 4;
    localparam int MAX_PACKETS = 18;
    localparam int CTRL_TAIL   = 12;
    localparam int CTRL_LEAD   = 4;

    logic        clk_pixel    = 1'b0;
    logic        reset_n      = 1'b0;
    logic        blank_start  = 1'b0;
    logic [11:0] blank_length = 12'd0;
    logic [3:0]  req          = 4'd0;
    logic [3:0]  grant;
    logic [1:0]  packet_sel;
    logic        packet_enable;
    logic [4:0]  packet_pixel_counter;
    logic [2:0]  mode;
    logic        overrun;

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int en_count = 0;
    bit chk_on   = 1'b0;

    always #5 clk_pixel = ~clk_pixel;

    data_island_scheduler #(
        .NUM_REQ(NUM_REQ),
        .MAX_PACKETS(MAX_PACKETS),
        .CTRL_TAIL(CTRL_TAIL),
        .CTRL_LEAD(CTRL_LEAD)
    ) dut (
        .clk_pixel(clk_pixel),
        .reset_n(reset_n),
        .blank_start(blank_start),
        .blank_length(blank_length),
        .req(req),
        .grant(grant),
        .packet_sel(packet_sel),
        .packet_enable(packet_enable),
        .packet_pixel_counter(packet_pixel_counter),
        .mode(mode),
        .overrun(overrun)
    );

    task automatic check_output(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: tracks time since the accepted blank_start and the island's offset,
    // deciding packets from the remaining-pixel budget and producing next-cycle outputs.
    bit         win_act, isl, m_start;
    int         tn, len_m, u, v, pkts, trail_at, rr, w, idx;
    logic [3:0] e_grant;
    int         e_mode, e_ppc, e_sel;
    bit         e_en, e_ovr;

    always @(posedge clk_pixel) begin
        if (!reset_n) begin
            win_act = 0; isl = 0; rr = 1; pkts = 0; trail_at = -1; tn = 0; u = 0;
            e_grant = '0; e_mode = 0; e_ppc = 0; e_sel = 0; e_en = 0; e_ovr = 0;
        end else begin
            m_start = 0;
            if (blank_start && isl) e_ovr = 1;
            if (blank_start && !isl) begin
                win_act = 1; tn = 0; len_m = int'(blank_length);
            end else if (win_act || isl) begin
                tn++;
            end
            if (isl) u++;
            if (win_act && !isl && !blank_start && tn == CTRL_LEAD) begin
                win_act = 0;
                if (req != 0 && len_m - 1 - tn >= 44 + CTRL_TAIL) begin
                    isl = 1; u = -1; pkts = 0; trail_at = -1;
                end
            end
            if (isl && u == 9) m_start = 1;
            if (isl && u >= 10 && trail_at < 0 && (u - 10) % 32 == 31) begin
                if (req != 0 && pkts < MAX_PACKETS && len_m - 1 - tn >= 34 + CTRL_TAIL)
                    m_start = 1;
                else
                    trail_at = u + 1;
            end
            e_grant = '0; e_en = 0; e_ppc = 0; e_mode = 0;
            if (isl) begin
                v = u + 1;
                if (v < 8) e_mode = 1;
                else if (v < 10) e_mode = 2;
                else if (trail_at >= 0 && v >= trail_at) begin
                    if (v < trail_at + 2) e_mode = 4;
                    else isl = 0;
                end else begin
                    e_mode = 3;
                    e_ppc  = (v - 10) % 32;
                end
            end
            if (m_start) begin
                e_en = 1;
                pkts++;
                w = -1;
                if (req[0]) w = 0;
                else begin
                    for (int k = 0; k < NUM_REQ - 1; k++) begin
                        idx = 1 + ((rr - 1 + k) % (NUM_REQ - 1));
                        if (w < 0 && req[idx[1:0]]) w = idx;
                    end
                end
                if (w >= 0) begin
                    e_grant[w[1:0]] = 1'b1;
                    e_sel = w;
                    if (w != 0) rr = 1 + (w % (NUM_REQ - 1));
                end
            end
        end
    end

    always @(negedge clk_pixel) begin
        if (chk_on) begin
            check_output("grant", int'(grant), int'(e_grant));
            check_output("packet_sel", int'(packet_sel), e_sel);
            check_output("packet_enable", int'(packet_enable), int'(e_en));
            check_output("pixel_counter", int'(packet_pixel_counter), e_ppc);
            check_output("mode", int'(mode), e_mode);
            check_output("overrun", int'(overrun), int'(e_ovr));
            if (packet_enable) en_count++;
        end
    end

    task automatic advance_to(input int k);
        while (cyc < k) begin
            @(posedge clk_pixel);
            #1;
            cyc++;
        end
    endtask

    task automatic at_cycle(input int k);
        advance_to(k);
        @(negedge clk_pixel);
    endtask

    // Pulses blank_start for one cycle (cycle 0) and sets the request vector.
    task automatic apply_stimulus(input int len, input logic [3:0] r);
        @(posedge clk_pixel);
        #1;
        cyc          = 0;
        blank_start  = 1'b1;
        blank_length = 12'(len);
        req          = r;
        @(posedge clk_pixel);
        #1;
        blank_start = 1'b0;
        cyc         = 1;
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge clk_pixel);
        #1;
        chk_on = 1'b1;
        @(negedge clk_pixel);
        check_output("reset_mode", int'(mode), 0);
        check_output("reset_grant", int'(grant), 0);
        check_output("reset_overrun", int'(overrun), 0);
        check_output("reset_sel", int'(packet_sel), 0);
        reset_n = 1'b1;

        // Three packets with req[0] held.
        apply_stimulus(138, 4'b0001);
        at_cycle(4);   check_output("s1_mode_c4", int'(mode), 0);
        at_cycle(5);   check_output("s1_mode_c5", int'(mode), 1);
        at_cycle(12);  check_output("s1_mode_c12", int'(mode), 1);
        at_cycle(13);  check_output("s1_mode_c13", int'(mode), 2);
        at_cycle(15);  check_output("s1_en_c15", int'(packet_enable), 1);
                       check_output("s1_grant_c15", int'(grant), 1);
                       check_output("s1_mode_c15", int'(mode), 3);
        at_cycle(46);  check_output("s1_ppc_c46", int'(packet_pixel_counter), 31);
        at_cycle(47);  check_output("s1_en_c47", int'(packet_enable), 1);
        at_cycle(79);  check_output("s1_en_c79", int'(packet_enable), 1);
        at_cycle(110); check_output("s1_mode_c110", int'(mode), 3);
        at_cycle(111); check_output("s1_mode_c111", int'(mode), 4);
        at_cycle(112); check_output("s1_mode_c112", int'(mode), 4);
        at_cycle(113); check_output("s1_mode_c113", int'(mode), 0);
        advance_to(120);

        // Budget one short of opening an island.
        apply_stimulus(60, 4'b0010);
        at_cycle(5);  check_output("s2_mode_c5", int'(mode), 0);
        at_cycle(15); check_output("s2_grant_c15", int'(grant), 0);
        advance_to(40);

        // Exactly enough to open: one packet, then trailing guard.
        apply_stimulus(61, 4'b0001);
        at_cycle(5);  check_output("s2b_mode_c5", int'(mode), 1);
        at_cycle(15); check_output("s2b_grant_c15", int'(grant), 1);
        at_cycle(47); check_output("s2b_mode_c47", int'(mode), 4);
        at_cycle(49); check_output("s2b_mode_c49", int'(mode), 0);
        advance_to(60);

        // Continuation budget boundary: 93 allows a second packet, 92 does not.
        apply_stimulus(93, 4'b0001);
        at_cycle(47); check_output("s2c_en_c47", int'(packet_enable), 1);
        at_cycle(79); check_output("s2c_mode_c79", int'(mode), 4);
        advance_to(90);
        apply_stimulus(92, 4'b0001);
        at_cycle(47); check_output("s2d_mode_c47", int'(mode), 4);
        advance_to(60);

        // Round-robin among 1..3, then req[0] dominance.
        apply_stimulus(138, 4'b1110);
        at_cycle(15);  check_output("s3_grant_p1", int'(grant), 2);
                       check_output("s3_sel_p1", int'(packet_sel), 1);
        at_cycle(47);  check_output("s3_grant_p2", int'(grant), 4);
        at_cycle(79);  check_output("s3_grant_p3", int'(grant), 8);
        at_cycle(100); check_output("s3_sel_hold", int'(packet_sel), 3);
        advance_to(120);
        apply_stimulus(138, 4'b1111);
        at_cycle(15); check_output("s3b_grant_p1", int'(grant), 1);
        at_cycle(47); check_output("s3b_grant_p2", int'(grant), 1);
        at_cycle(79); check_output("s3b_grant_p3", int'(grant), 1);
                      check_output("s3b_sel_p3", int'(packet_sel), 0);
        advance_to(120);

        // Long blanking caps the island at MAX_PACKETS.
        apply_stimulus(4095, 4'b0100);
        en_count = 0;
        at_cycle(559); check_output("s4_grant_p18", int'(grant), 4);
                       check_output("s4_sel_p18", int'(packet_sel), 2);
        at_cycle(591); check_output("s4_mode_c591", int'(mode), 4);
        at_cycle(593); check_output("s4_mode_c593", int'(mode), 0);
        check_output("s4_packet_count", en_count, 18);
        advance_to(600);

        // Mid-island blank_start sets overrun; reset then clears everything immediately.
        apply_stimulus(138, 4'b0001);
        advance_to(25);
        blank_start  = 1'b1;
        blank_length = 12'd500;
        advance_to(26);
        blank_start = 1'b0;
        at_cycle(26); check_output("s5_overrun_c26", int'(overrun), 1);
        at_cycle(47); check_output("s5_en_c47", int'(packet_enable), 1);
        advance_to(60);
        reset_n = 1'b0;
        at_cycle(61); check_output("s5_mode_rst", int'(mode), 0);
                      check_output("s5_overrun_rst", int'(overrun), 0);
                      check_output("s5_grant_rst", int'(grant), 0);
        advance_to(64);
        reset_n = 1'b1;
        at_cycle(75); check_output("s5_mode_after", int'(mode), 0);
        advance_to(80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_island_scheduler.md
DATA_ISLAND_SCHEDULER -- requirements
Module: data_island_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of packet requesters; index 0 is the audio clock regeneration source.
REQ-002 Parameter MAX_PACKETS, default 18: maximum packets per data island.
REQ-003 Parameter CTRL_TAIL, default 12: minimum control-period pixels after the trailing guard band.
REQ-004 Parameter CTRL_LEAD, default 4: control-period pixels between blank_start and the preamble.
REQ-005 clk_pixel  input  1  pixel clock; the block's only clock.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 blank_start  input  1  one-cycle pulse on the first pixel of horizontal blanking.
REQ-008 blank_length  input  12  blanking length in pixels, valid with blank_start.
REQ-009 req  input  NUM_REQ  per-requester packet request, held high until granted.
REQ-010 grant  output  NUM_REQ  one-hot, one-cycle grant pulse.
REQ-011 packet_sel  output  $clog2(NUM_REQ)  index of the requester owning the current packet.
REQ-012 packet_enable  output  1  one-cycle pulse on pixel 0 of each packet.
REQ-013 packet_pixel_counter  output  5  pixel index within the current packet.
REQ-014 mode  output  3  period code: 0 control, 1 preamble, 2 leading guard, 3 data, 4 trailing guard.
REQ-015 overrun  output  1  sticky; set when blank_start is received mid-island.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 FSM states SHALL be IDLE, CTRL_WAIT, PREAMBLE, LEAD_GUARD, PACKET, TRAIL_GUARD and DONE.
REQ-018 Cycle numbering SHALL count the blank_start cycle as cycle 0.
- rem = blank_length - 1 - (cycles elapsed since cycle 0); this is the number of pixels remaining after the current cycle.
- rem saturates at 0.
REQ-019 IDLE/DONE SHALL respond to blank_start as follows.
- Latch blank_length.
- Enter CTRL_WAIT.
- Stay in CTRL_WAIT for CTRL_LEAD cycles.
REQ-020 On the last CTRL_WAIT cycle the FSM SHALL branch as follows.
- If |req and rem >= 44+CTRL_TAIL: enter PREAMBLE.
- Otherwise: enter DONE.
REQ-021 Period lengths SHALL be fixed.
- PREAMBLE: 8 cycles.
- LEAD_GUARD: 2 cycles.
- PACKET: 32 cycles, with packet_pixel_counter 0..31.
- TRAIL_GUARD: 2 cycles.
- TRAIL_GUARD then enters DONE.
REQ-022 On the last LEAD_GUARD cycle and on packet_pixel_counter 31, the arbiter SHALL select a winner.
- The selected requester receives grant, packet_sel is updated, and packet_enable asserts, all on the following cycle (pixel 0).
REQ-023 After pixel 31, the FSM SHALL start another packet only if all of the following hold; otherwise it enters TRAIL_GUARD.
- |req
- packets_in_island < MAX_PACKETS
- rem >= 34+CTRL_TAIL
REQ-024 Arbitration SHALL give req[0] strict priority.
- req[NUM_REQ-1:1] are served round-robin.
- The round-robin pointer advances to one past the last granted index in 1..NUM_REQ-1.
- The pointer persists across islands.
REQ-025 A request SHALL be considered only at the decision points in REQ-022/023.
- A requester may drop req on the cycle after its grant.
- A req that is still high at the next decision point counts as a new request.
REQ-026 packet_sel SHALL hold its value through the packet and until the next grant.
REQ-027 packet_pixel_counter SHALL read 0 outside PACKET.
REQ-028 mode SHALL read 0 in IDLE, CTRL_WAIT and DONE.
REQ-029 blank_start received in IDLE, DONE or CTRL_WAIT SHALL restart CTRL_WAIT with a new latch.
REQ-030 blank_start received in PREAMBLE through TRAIL_GUARD SHALL be ignored for sequencing and SHALL set overrun.
REQ-031 blank_start and a decision point in the same cycle SHALL evaluate the decision on the old budget.
REQ-032 An island SHALL never contain zero packets.
REQ-033 grant SHALL never be asserted outside PACKET pixel 0.

Reset
REQ-034 While reset_n is low at a clk_pixel edge, the following SHALL be cleared.
- state=IDLE, rem=0, packets_in_island=0, round-robin pointer=1.
- grant=0, packet_sel=0, packet_enable=0, packet_pixel_counter=0, mode=0, overrun=0.
REQ-035 Reset mid-island SHALL return mode to 0 on the next cycle with no trailing guard, and no grant SHALL be issued.

Verification
REQ-036 blank_length=138, req[0] held high -> island fills 3 packets.
- PREAMBLE cycles 5-12, LEAD_GUARD cycles 13-14.
- Packets start at cycles 15, 47 and 79.
- TRAIL_GUARD cycles 111-112, then mode=0.
REQ-037 blank_length=60, req=4'b0010 -> no island opens (rem=55 < 56); mode stays 0, no grant.
REQ-038 req=4'b1110 held for 3 packets, pointer=1 -> grants go to 1, 2, 3 in that order; with req=4'b1111, grant[0] wins every packet.
REQ-039 blank_length=4095, req[2] always high -> exactly 18 packets, then TRAIL_GUARD.
REQ-040 blank_start pulsed at packet pixel 10 -> overrun=1, island continues unchanged; then reset_n low -> mode=0 and overrun=0 next cycle.
